// File: rtl/smm1_pkg.sv
// Shared constants and issue-FSM encoding for the SMM1 operand loader slice.
// Element indices follow the row/column naming of the 2x2 operands.
package smm1_pkg;

    localparam int SMM1_ELEMS = 4;
    localparam int SMM1_BEATS = 8;

    localparam int IDX_00 = 0;
    localparam int IDX_01 = 1;
    localparam int IDX_10 = 2;
    localparam int IDX_11 = 3;

    typedef enum logic [1:0] {
        ISSUE_IDLE = 2'd0,
        ISSUE_REQ  = 2'd1,
        ISSUE_BUSY = 2'd2
    } issue_state_t;

endpackage

// File: rtl/smm1_operand_loader_if.sv
// Stream, controller-handshake and operand signals between the loader and its neighbours.
// The loader is the slave; the upstream feeder/controller side uses master.
interface smm1_operand_loader_if #(parameter int DW = 8);
    import smm1_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [DW-1:0]              in_data;
    logic                       in_last;
    logic                       load_ts;
    logic                       write_out;
    logic                       load;
    logic [SMM1_ELEMS*DW-1:0]   a_flat;
    logic [SMM1_ELEMS*DW-1:0]   b_flat;
    logic                       busy;
    logic                       err;

    modport slave (
        input  in_valid, in_data, in_last, load_ts, write_out,
        output in_ready, load, a_flat, b_flat, busy, err
    );

    modport master (
        output in_valid, in_data, in_last, load_ts, write_out,
        input  in_ready, load, a_flat, b_flat, busy, err
    );

endinterface

// File: rtl/smm1_operand_bank.sv
// One operand bank: eight DW-bit elements written by beat index, read in parallel.
// Beats 0..3 form A and beats 4..7 form B, each packed with element 00 in the low bits.
module smm1_operand_bank
    import smm1_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     we,
    input  logic [2:0]               idx,
    input  logic [DW-1:0]            wdata,
    output logic [SMM1_ELEMS*DW-1:0] a_flat,
    output logic [SMM1_ELEMS*DW-1:0] b_flat
);

    logic [DW-1:0] mem [SMM1_BEATS];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < SMM1_BEATS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign a_flat = {mem[IDX_11], mem[IDX_10], mem[IDX_01], mem[IDX_00]};
    assign b_flat = {mem[SMM1_ELEMS + IDX_11], mem[SMM1_ELEMS + IDX_10],
                     mem[SMM1_ELEMS + IDX_01], mem[SMM1_ELEMS + IDX_00]};

endmodule

// File: rtl/smm1_operand_loader.sv
// Ping-pong operand loader: fills one bank from the element stream while the other
// bank is held stable for the SMM1 controller between load and write_out.
module smm1_operand_loader
    import smm1_pkg::*;
#(
    parameter int DW = 8
) (
    input logic                  clk,
    input logic                  rst,
    smm1_operand_loader_if.slave bus
);

    issue_state_t state, state_next;
    logic [1:0]   full, full_next, filled;
    logic         wr_bank, rd_bank;
    logic [2:0]   beat;
    logic         load_q, busy_q, err_q;
    logic         accept, early_last, complete, retire;
    logic [1:0]   bank_we, bank_clr;
    logic [SMM1_ELEMS*DW-1:0] bank_a [2];
    logic [SMM1_ELEMS*DW-1:0] bank_b [2];

    assign bus.in_ready = !rst & !full[wr_bank];
    assign accept       = bus.in_valid & bus.in_ready;
    assign early_last   = accept & bus.in_last & (beat != 3'd7);
    assign complete     = accept & (beat == 3'd7);
    assign retire       = (state == ISSUE_BUSY) & bus.write_out;

    // Issue decisions look at banks completing on this same edge so load follows the last beat directly.
    always_comb begin
        filled     = full | (complete ? (2'b01 << wr_bank) : 2'b00);
        full_next  = filled;
        if (retire) begin
            full_next[rd_bank] = 1'b0;
        end
        state_next = state;
        case (state)
            ISSUE_IDLE: if (filled[rd_bank]) state_next = ISSUE_REQ;
            ISSUE_REQ:  if (bus.load_ts) state_next = ISSUE_BUSY;
            ISSUE_BUSY: if (bus.write_out) state_next = filled[~rd_bank] ? ISSUE_REQ : ISSUE_IDLE;
            default:    state_next = ISSUE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ISSUE_IDLE;
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            beat    <= 3'd0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_next;
            full   <= full_next;
            load_q <= (state_next == ISSUE_REQ);
            busy_q <= (state_next != ISSUE_IDLE);
            if (retire) begin
                rd_bank <= ~rd_bank;
            end
            if (complete) begin
                wr_bank <= ~wr_bank;
                beat    <= 3'd0;
            end else if (early_last) begin
                beat    <= 3'd0;
            end else if (accept) begin
                beat    <= beat + 3'd1;
            end
            if (early_last | (complete & ~bus.in_last)) begin
                err_q <= 1'b1;
            end
        end
    end

    // A frame cut short by in_last is wiped so stale partial data never lingers in the bank.
    always_comb begin
        bank_we           = 2'b00;
        bank_clr          = 2'b00;
        bank_we[wr_bank]  = accept & ~early_last;
        bank_clr[wr_bank] = early_last;
        if (rst) begin
            bank_clr = 2'b11;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        smm1_operand_bank #(.DW(DW)) u_bank (
            .clk    (clk),
            .clr    (bank_clr[g]),
            .we     (bank_we[g]),
            .idx    (beat),
            .wdata  (bus.in_data),
            .a_flat (bank_a[g]),
            .b_flat (bank_b[g])
        );
    end

    assign bus.a_flat = bank_a[rd_bank];
    assign bus.b_flat = bank_b[rd_bank];
    assign bus.load   = load_q;
    assign bus.busy   = busy_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_smm1_operand_loader.sv
// Self-checking bench for smm1_operand_loader: directed scenarios plus a randomized
// run checked against a frame-queue reference model of the loader.
module tb_smm1_operand_loader;

    localparam int DW = 8;
    localparam int FW = 4 * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    smm1_operand_loader_if #(.DW(DW)) bus ();

    smm1_operand_loader #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: frames completed but not yet retired, in arrival order.
    int            occupied  = 0;
    bit            acked     = 0;
    bit            err_exp   = 0;
    int            beat_cnt  = 0;
    int            retired   = 0;
    int            completed = 0;
    logic [DW-1:0] frame [8];
    logic [FW-1:0] exp_a [$];
    logic [FW-1:0] exp_b [$];

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l,
                         input logic ts, input logic wo);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.load_ts   = ts;
        bus.write_out = wo;
    endtask

    // Advance one clock edge and update the model from the inputs presented at that edge.
    task automatic step();
        bit acc, ret, ack;
        acc = !rst && bus.in_valid && (occupied < 2);
        ret = !rst && bus.write_out && (occupied > 0) && acked;
        ack = !rst && bus.load_ts && (occupied > 0) && !acked;
        @(posedge clk);
        if (rst) begin
            occupied = 0; acked = 0; err_exp = 0; beat_cnt = 0;
            exp_a.delete(); exp_b.delete();
        end else begin
            if (ret) begin
                occupied--; acked = 0; retired++;
                void'(exp_a.pop_front());
                void'(exp_b.pop_front());
            end
            if (ack) acked = 1;
            if (acc) begin
                if (bus.in_last && beat_cnt < 7) begin
                    beat_cnt = 0; err_exp = 1;
                end else begin
                    frame[beat_cnt] = bus.in_data;
                    if (beat_cnt == 7) begin
                        if (!bus.in_last) err_exp = 1;
                        exp_a.push_back({frame[3], frame[2], frame[1], frame[0]});
                        exp_b.push_back({frame[7], frame[6], frame[5], frame[4]});
                        occupied++; completed++; beat_cnt = 0;
                    end else begin
                        beat_cnt++;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, '0, 0, 0, 0);
        step(); step();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.load !== 1'b0) begin failures++; $display("[TB] FAIL rst_load: got %b expected 0", bus.load); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("[TB] FAIL rst_err: got %b expected 0", bus.err); end
        checks++; if (bus.a_flat !== '0 || bus.b_flat !== '0) begin failures++; $display("[TB] FAIL rst_flat: got %h/%h expected 0/0", bus.a_flat, bus.b_flat); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_release_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < 8; i++) begin
            drive(1, DW'(i + 1), i == 7, 0, 0);
            step();
        end
        drive(0, '0, 0, 0, 0);
        checks++; if (bus.load !== 1'b1) begin failures++; $display("[TB] FAIL single_load: got %b expected 1", bus.load); end
        checks++; if (bus.a_flat !== 32'h04030201) begin failures++; $display("[TB] FAIL single_a: got %h expected 04030201", bus.a_flat); end
        checks++; if (bus.b_flat !== 32'h08070605) begin failures++; $display("[TB] FAIL single_b: got %h expected 08070605", bus.b_flat); end
        step(); step();
        drive(0, '0, 0, 1, 0); step();
        drive(0, '0, 0, 0, 0);
        checks++; if (bus.load !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL single_ack: got load=%b busy=%b expected load=0 busy=1", bus.load, bus.busy); end
        step();
        drive(0, '0, 0, 0, 1); step();
        drive(0, '0, 0, 0, 0);
        checks++; if (bus.busy !== 1'b0 || bus.load !== 1'b0) begin failures++; $display("[TB] FAIL single_retire: got busy=%b load=%b expected 0/0", bus.busy, bus.load); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] data [24];
        int sent = 0, ret0 = retired, phase = 0, cnt = 0;
        bit wo_seen = 0, probed = 0;
        logic v;
        for (int i = 0; i < 24; i++) data[i] = DW'($urandom);
        for (int cyc = 0; cyc < 400 && (retired - ret0) < 3; cyc++) begin
            checks++; if (bus.load !== (occupied > 0 && !acked)) begin failures++; $display("[TB] FAIL b2b_load cyc %0d: got %b expected %b", cyc, bus.load, occupied > 0 && !acked); end
            checks++; if (bus.in_ready !== (occupied < 2)) begin failures++; $display("[TB] FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, bus.in_ready, occupied < 2); end
            if (occupied > 0) begin
                checks++; if (bus.a_flat !== exp_a[0] || bus.b_flat !== exp_b[0]) begin failures++; $display("[TB] FAIL b2b_data cyc %0d: got %h/%h expected %h/%h", cyc, bus.a_flat, bus.b_flat, exp_a[0], exp_b[0]); end
            end
            if (sent == 16 && !wo_seen && !probed) begin
                probed = 1;
                checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_beat17_stall: got %b expected 0", bus.in_ready); end
            end
            v = (sent < 24);
            drive(v, v ? data[sent] : '0, v && (sent % 8 == 7), 0, 0);
            case (phase)
                0: if (bus.load) begin phase = 1; cnt = 1; end
                1: if (cnt == 0) begin bus.load_ts = 1; phase = 2; cnt = 12; end else cnt--;
                default: if (cnt == 0) begin bus.write_out = 1; wo_seen = 1; phase = 0; end else cnt--;
            endcase
            if (v && bus.in_ready) sent++;
            step();
        end
        drive(0, '0, 0, 0, 0);
        checks++; if ((retired - ret0) != 3 || !probed) begin failures++; $display("[TB] FAIL b2b_complete: got %0d retired (probe %0d) expected 3 (1)", retired - ret0, probed); end
    endtask

    task automatic test_early_last();
        for (int i = 0; i < 5; i++) begin
            drive(1, DW'(8'h50 + i), i == 4, 0, 0);
            step();
        end
        drive(0, '0, 0, 0, 0);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("[TB] FAIL early_err: got %b expected 1", bus.err); end
        step(); step();
        checks++; if (bus.load !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL early_no_load: got load=%b busy=%b expected 0/0", bus.load, bus.busy); end
        for (int i = 0; i < 8; i++) begin
            drive(1, DW'(8'h60 + i), i == 7, 0, 0);
            step();
        end
        drive(0, '0, 0, 0, 0);
        checks++; if (bus.load !== 1'b1) begin failures++; $display("[TB] FAIL early_next_load: got %b expected 1", bus.load); end
        checks++; if (bus.a_flat !== 32'h63626160 || bus.b_flat !== 32'h67666564) begin failures++; $display("[TB] FAIL early_next_data: got %h/%h expected 63626160/67666564", bus.a_flat, bus.b_flat); end
        drive(0, '0, 0, 1, 0); step();
        drive(0, '0, 0, 0, 1); step();
        drive(0, '0, 0, 0, 0);
        checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL early_sticky: got err=%b busy=%b expected 1/0", bus.err, bus.busy); end
    endtask

    task automatic test_wo_same_edge();
        for (int i = 0; i < 8; i++) begin
            drive(1, DW'(8'h11 + i), i == 7, 0, 0);
            step();
        end
        drive(0, '0, 0, 1, 0); step();
        for (int i = 0; i < 8; i++) begin
            drive(1, DW'(8'h21 + i), i == 7, 0, i == 7);
            step();
        end
        drive(0, '0, 0, 0, 0);
        checks++; if (bus.load !== 1'b1 || bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL same_edge_load: got load=%b in_ready=%b expected 1/1", bus.load, bus.in_ready); end
        checks++; if (bus.a_flat !== 32'h24232221 || bus.b_flat !== 32'h28272625) begin failures++; $display("[TB] FAIL same_edge_data: got %h/%h expected 24232221/28272625", bus.a_flat, bus.b_flat); end
        drive(0, '0, 0, 1, 0); step();
        drive(0, '0, 0, 0, 1); step();
        drive(0, '0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            drive(1, DW'(8'h31 + i), i == 7, 0, 0);
            step();
        end
        drive(0, '0, 0, 1, 0); step();
        for (int i = 0; i < 5; i++) begin
            drive(1, DW'(8'h71 + i), 0, 0, 0);
            step();
        end
        rst = 1'b1;
        drive(0, '0, 0, 0, 0);
        step();
        checks++; if (bus.load !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ctrl: got load=%b busy=%b err=%b in_ready=%b expected 0/0/0/0", bus.load, bus.busy, bus.err, bus.in_ready); end
        checks++; if (bus.a_flat !== '0 || bus.b_flat !== '0) begin failures++; $display("[TB] FAIL mid_rst_flat: got %h/%h expected 0/0", bus.a_flat, bus.b_flat); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1, DW'(8'h41 + i), i == 7, 0, 0);
            step();
        end
        drive(0, '0, 0, 0, 0);
        checks++; if (bus.load !== 1'b1 || bus.a_flat !== 32'h44434241 || bus.b_flat !== 32'h48474645) begin failures++; $display("[TB] FAIL mid_rst_fresh: got load=%b %h/%h expected 1 44434241/48474645", bus.load, bus.a_flat, bus.b_flat); end
        drive(0, '0, 0, 1, 0); step();
        drive(0, '0, 0, 0, 1); step();
        drive(0, '0, 0, 0, 0);
    endtask

    task automatic test_random();
        int ret0 = retired, c0 = completed, phase = 0, cnt = 0;
        logic v;
        for (int cyc = 0; cyc < 30000 && (retired - ret0) < 200; cyc++) begin
            checks++; if (bus.load !== (occupied > 0 && !acked)) begin failures++; $display("[TB] FAIL rand_load cyc %0d: got %b expected %b", cyc, bus.load, occupied > 0 && !acked); end
            checks++; if (bus.busy !== (occupied > 0)) begin failures++; $display("[TB] FAIL rand_busy cyc %0d: got %b expected %b", cyc, bus.busy, occupied > 0); end
            checks++; if (bus.in_ready !== (occupied < 2)) begin failures++; $display("[TB] FAIL rand_in_ready cyc %0d: got %b expected %b", cyc, bus.in_ready, occupied < 2); end
            checks++; if (bus.err !== err_exp) begin failures++; $display("[TB] FAIL rand_err cyc %0d: got %b expected %b", cyc, bus.err, err_exp); end
            if (occupied > 0) begin
                checks++; if (bus.a_flat !== exp_a[0] || bus.b_flat !== exp_b[0]) begin failures++; $display("[TB] FAIL rand_data cyc %0d: got %h/%h expected %h/%h", cyc, bus.a_flat, bus.b_flat, exp_a[0], exp_b[0]); end
            end
            v = ((completed - c0) < 200) && ($urandom_range(0, 99) < 70);
            drive(v, DW'($urandom), (beat_cnt == 7) ? ($urandom_range(0, 19) != 0) : 1'b0, 0, 0);
            case (phase)
                0: if (bus.load) begin phase = 1; cnt = $urandom_range(0, 5); end
                1: begin
                    if (cnt == 0) begin bus.load_ts = 1; phase = 2; cnt = $urandom_range(0, 5); end
                    else begin cnt--; bus.write_out = ($urandom_range(0, 9) == 0); end
                end
                default: if (cnt == 0) begin bus.write_out = 1; phase = 0; end else cnt--;
            endcase
            step();
        end
        drive(0, '0, 0, 0, 0);
        checks++; if ((retired - ret0) != 200) begin failures++; $display("[TB] FAIL rand_complete: got %0d retired expected 200", retired - ret0); end
    endtask

    initial begin
        drive(0, '0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset();
        test_early_last();
        test_wo_same_edge();
        test_reset_mid();
        test_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/smm1_operand_loader.md
# smm1_operand_loader

Upstream feeder for the level-1 Strassen matrix-multiply datapath. Collects a serial stream of 2x2 operand matrices A and B into one of two ping-pong banks and presents a complete bank, stable and parallel, to the SMM1 controller/datapath. Raises `load` to start a multiply. Holds the operands until the controller's `write_out` pulse retires them. While one bank is in service, the next operand frame fills the other bank.

## Interface
- `DW`, default 8: element width in bits (signed two's complement; the loader does not interpret values).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: stream element valid.
- `in_ready` out 1: loader can accept an element this cycle.
- `in_data` in DW: stream element.
- `in_last` in 1: marks the final (8th) element of a frame.
- `load_ts` in 1: controller LOAD_TS state indicator (operands captured).
- `write_out` in 1: controller WRITE_OUT state indicator (multiply retired).
- `load` out 1: request to start a multiply; level, registered.
- `a_flat` out 4*DW: A elements {A11,A10,A01,A00}; A00 in bits [DW-1:0].
- `b_flat` out 4*DW: B elements {B11,B10,B01,B00}, same packing as `a_flat`.
- `busy` out 1: a bank is issued and not yet retired.
- `err` out 1: sticky framing error flag.

## Operation
- Frame: 8 beats, in order A00,A01,A10,A11,B00,B01,B10,B11.
- A beat is accepted on a rising edge where `in_valid & in_ready`.
- State per bank: `full[1:0]`. Pointers: `wr_bank`, `rd_bank`. Beat counter: `beat[2:0]`. Issue FSM: ISSUE_IDLE, ISSUE_REQ, ISSUE_BUSY.
- `in_ready = !rst & !full[wr_bank]`.
- Accepted beat: store to `wr_bank` at index `beat`, then increment `beat`. On beat 7: set `full[wr_bank]`, toggle `wr_bank`, clear `beat` to 0.
- Issue FSM transitions:
  - ISSUE_IDLE -> ISSUE_REQ when `full[rd_bank]`. `load` goes 1 in the next cycle.
  - ISSUE_REQ -> ISSUE_BUSY on the edge where `load_ts` = 1. `load` drops in the following cycle.
  - ISSUE_BUSY -> ISSUE_IDLE on the edge where `write_out` = 1. At that edge: clear `full[rd_bank]` and toggle `rd_bank`.
- `busy` = 1 in ISSUE_REQ and ISSUE_BUSY.
- `a_flat`/`b_flat` are driven from `rd_bank` contents. They are stable from the first `load` cycle through the `write_out` cycle.
- Framing errors (both set `err`, which stays 1 until `rst`):
  - `in_last` on beat <7: partial bank discarded, `beat` cleared to 0, `wr_bank` unchanged.
  - Beat 7 without `in_last`: bank accepted normally.
- `load_ts` or `write_out` arriving outside the FSM state that expects it is ignored.

## Timing
- Reset values: `load`=0, `busy`=0, `err`=0, `a_flat`=0, `b_flat`=0, `in_ready`=0 while `rst` high. Both banks empty, `wr_bank`=`rd_bank`=0, `beat`=0, FSM in ISSUE_IDLE.
- First cycle after reset deasserts: `in_ready`=1.
- Latency: beat 7 accepted at edge t -> `load`=1 in cycle t+1 (when the FSM is in ISSUE_IDLE).
- `write_out` at edge t with the other bank already full -> `load` re-asserts in cycle t+1. The other bank's contents are on `a_flat`/`b_flat` from cycle t+1.
- Both banks full -> `in_ready`=0. After `write_out` at edge t, `in_ready`=1 in cycle t+1.
- `write_out` and beat 7 on the same edge: both take effect.
  - The beat completes the non-issued bank.
  - The issued bank is freed and `rd_bank` toggles onto the newly full bank.
  - `load`=1 next cycle.
- `rst` mid-frame or mid-issue: all state is discarded within one cycle. The controller's reset is applied on the same edge.
- Throughput: one element per cycle, with no bubbles while a bank is free.

## Structure
- Shared package `smm1_pkg` holds:
  - `SMM1_ELEMS`=4, `SMM1_BEATS`=8.
  - Element index constants `IDX_00`=0, `IDX_01`=1, `IDX_10`=2, `IDX_11`=3.
  - Issue-FSM state encoding (2 bits).
- Sub-module `smm1_operand_bank`: a single bank of 8 x DW registers with write-enable, a 3-bit write index, synchronous clear, and parallel `a_flat`/`b_flat` outputs.
- The loader instantiates two banks and a 2:1 output mux selected by `rd_bank`.

## Test plan
- Single frame 1..8, with the controller model answering `load_ts` 2 cycles after `load`:
  - `load` rises the cycle after beat 8.
  - `a_flat` = {4,3,2,1}, `b_flat` = {8,7,6,5}.
  - `busy` clears after `write_out`.
- Three back-to-back frames with continuous `in_valid`:
  - Bank 0 is issued while bank 1 fills.
  - `in_ready`=0 on the 17th beat until the first `write_out`.
  - Frames are issued in order, with no data corruption.
- `in_last` on beat 5:
  - `err`=1, no `load`.
  - The next 8-beat frame issues correctly.
  - `err` remains 1.
- `write_out` on the same edge as beat 8 of frame 2:
  - `load`=1 the next cycle with frame-2 operands.
  - `in_ready`=1.
- `rst` pulsed after 5 beats of frame 1 while bank 0 is in ISSUE_BUSY:
  - All outputs return to their reset values.
  - A fresh frame afterwards produces correct operands.
- Random `in_valid` gaps and random `load_ts`/`write_out` delays (1-6 cycles), 200 frames: a scoreboard matches every issued operand set.
